mcu_tx_sched: RTL and testbench

Scheduler for the FPGA-to-MCU command queue. It captures write events from six host-side sources into per-source pending slots and shares the 24-bit command FIFO between them with round-robin arbitration, so no event is lost when sources fire together. When nothing is pending and the FIFO is empty, it inserts NOPE fillers. It sits between the host peripherals (UART, RTC, debug taps) and the SPI-slave TX FIFO inside the MCU interface.

---
 rtl/mcu_pkg.sv | 26 ++
 rtl/mcu_rr_arb.sv | 31 +++
 rtl/mcu_tx_sched.sv | 136 +++++++++++++
 tb/tb_mcu_tx_sched.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared constants for the FPGA-to-MCU command path: command codes,
// UART sub-addresses and the scheduler's source indices.
package mcu_pkg;

    localparam logic [7:0] CMD_RTC        = 8'hFA;
    localparam logic [7:0] CMD_UART       = 8'hFC;
    localparam logic [7:0] CMD_DEBUG_ADDR = 8'h30;
    localparam logic [7:0] CMD_DEBUG_DATA = 8'h31;
    localparam logic [7:0] CMD_NOPE       = 8'hFF;

    localparam logic [7:0] UART_SUB_TX    = 8'h00;
    localparam logic [7:0] UART_SUB_DLL   = 8'h01;
    localparam logic [7:0] UART_SUB_DLM   = 8'h02;
    localparam logic [7:0] UART_SUB_TX_M1 = 8'h03;

    localparam int NSRC         = 6;
    localparam int SRC_UART     = 0;
    localparam int SRC_DLL      = 1;
    localparam int SRC_DLM      = 2;
    localparam int SRC_RTC      = 3;
    localparam int SRC_DBG_ADDR = 4;
    localparam int SRC_DBG_DATA = 5;

    typedef logic [23:0] word_t;

endpackage

// File: rtl/mcu_rr_arb.sv
// Combinational round-robin pick: first pending slot at or after ptr, modulo N.
module mcu_rr_arb
    import mcu_pkg::*;
#(
    parameter int N = NSRC
) (
    input  logic [NSRC-1:0] pend,
    input  logic [2:0]      ptr,
    output logic [2:0]      grant,
    output logic            valid
);

    logic [3:0] idx;

    // Walk from the farthest offset down so the nearest pending slot wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= 4'(N))
                idx = idx - 4'(N);
            if (pend[idx[2:0]]) begin
                grant = idx[2:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mcu_tx_sched.sv
// Six-source round-robin scheduler feeding the 24-bit MCU command FIFO.
// Define MCU_TX_SCHED_DEBUG_EN to enable the debug address/data sources.
module mcu_tx_sched
    import mcu_pkg::*;
#(
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              uart_tx_wr,
    input  logic [7:0]        uart_tx_data,
    input  logic [1:0]        uart_tx_mode,
    input  logic              uart_dll_wr,
    input  logic [7:0]        uart_dll,
    input  logic              uart_dlm_wr,
    input  logic [7:0]        uart_dlm,
    input  logic              rtc_cs,
    input  logic              rtc_wr_n,
    input  logic [7:0]        rtc_a,
    input  logic [7:0]        rtc_di,
    input  logic              busy,
    input  logic [15:0]       debug_addr,
    input  logic [15:0]       debug_data,
    input  logic              queue_full,
    input  logic              queue_empty,
    output logic              queue_wr,
    output logic [23:0]       queue_di,
    output logic [DROP_W-1:0] drop_cnt
);

`ifdef MCU_TX_SCHED_DEBUG_EN
    localparam int NACT = 6;
`else
    localparam int NACT = 4;
`endif

    logic [NSRC-1:0]             pend, ev, gnt;
    logic [NSRC-1:0][23:0]       word, nw;
    logic [2:0]                  rr_ptr, grant;
    logic                        gv, fill_hold;
    logic [2:0]                  drops;
    logic [DROP_W:0]             drop_sum;
    logic [DROP_W-1:0]           drop_next;

    mcu_rr_arb #(.N(NACT)) u_arb (
        .pend  (pend),
        .ptr   (rr_ptr),
        .grant (grant),
        .valid (gv)
    );

`ifdef MCU_TX_SCHED_DEBUG_EN
    logic [15:0] last_addr, last_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_addr <= '0;
            last_data <= '0;
        end else begin
            if (ev[SRC_DBG_ADDR]) last_addr <= debug_addr;
            if (ev[SRC_DBG_DATA]) last_data <= debug_data;
        end
    end
`else
    logic unused_dbg;
    assign unused_dbg = ^{debug_addr, debug_data};
`endif

    always_comb begin
        ev = '0;
        nw = '0;
        ev[SRC_UART] = uart_tx_wr & ~uart_tx_mode[1];
        nw[SRC_UART] = {CMD_UART, uart_tx_mode[0] ? UART_SUB_TX_M1 : UART_SUB_TX, uart_tx_data};
        ev[SRC_DLL]  = uart_dll_wr;
        nw[SRC_DLL]  = {CMD_UART, UART_SUB_DLL, uart_dll};
        ev[SRC_DLM]  = uart_dlm_wr;
        nw[SRC_DLM]  = {CMD_UART, UART_SUB_DLM, uart_dlm};
        ev[SRC_RTC]  = rtc_cs & ~rtc_wr_n & ~busy & (rtc_a != 8'h0C) & (rtc_a < 8'hF0);
        nw[SRC_RTC]  = {CMD_RTC, rtc_a, rtc_di};
`ifdef MCU_TX_SCHED_DEBUG_EN
        ev[SRC_DBG_ADDR] = debug_addr != last_addr;
        nw[SRC_DBG_ADDR] = {CMD_DEBUG_ADDR, debug_addr};
        ev[SRC_DBG_DATA] = debug_data != last_data;
        nw[SRC_DBG_DATA] = {CMD_DEBUG_DATA, debug_data};
`endif
    end

    // A slot being granted this cycle can absorb a new event without a drop.
    always_comb begin
        gnt = '0;
        if (!queue_full && gv)
            gnt[grant] = 1'b1;
        drops = '0;
        for (int i = SRC_UART; i <= SRC_RTC; i++)
            if (ev[i] && pend[i] && !gnt[i])
                drops = drops + 3'd1;
        drop_sum  = {1'b0, drop_cnt} + (DROP_W+1)'(drops);
        drop_next = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            queue_wr  <= 1'b0;
            queue_di  <= '0;
            drop_cnt  <= '0;
            pend      <= '0;
            word      <= '0;
            rr_ptr    <= '0;
            fill_hold <= 1'b0;
        end else begin
            queue_wr  <= 1'b0;
            fill_hold <= 1'b0;
            drop_cnt  <= drop_next;
            if (!queue_full) begin
                if (gv) begin
                    queue_wr <= 1'b1;
                    queue_di <= word[grant];
                    rr_ptr   <= (grant == 3'(NACT - 1)) ? 3'd0 : grant + 3'd1;
                end else if (queue_empty && !fill_hold) begin
                    queue_wr  <= 1'b1;
                    queue_di  <= {CMD_NOPE, 16'h0000};
                    fill_hold <= 1'b1;
                end
            end
            for (int i = 0; i < NSRC; i++) begin
                if (ev[i] && !(pend[i] && !gnt[i] && i < SRC_DBG_ADDR)) begin
                    word[i] <= nw[i];
                    pend[i] <= 1'b1;
                end else if (gnt[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mcu_tx_sched.sv
// Directed bench for mcu_tx_sched: vector table for single events plus
// hand sequences for arbitration order, drops, coalescing, filler and reset.
module tb_mcu_tx_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        uart_tx_wr, uart_dll_wr, uart_dlm_wr;
    logic [7:0]  uart_tx_data, uart_dll, uart_dlm;
    logic [1:0]  uart_tx_mode;
    logic        rtc_cs, rtc_wr_n, busy;
    logic [7:0]  rtc_a, rtc_di;
    logic [15:0] debug_addr, debug_data;
    logic        queue_full, queue_empty;
    logic        queue_wr;
    logic [23:0] queue_di;
    logic [7:0]  drop_cnt;

    int tests = 0;
    int fails = 0;

    mcu_tx_sched #(.DROP_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .uart_tx_wr(uart_tx_wr), .uart_tx_data(uart_tx_data), .uart_tx_mode(uart_tx_mode),
        .uart_dll_wr(uart_dll_wr), .uart_dll(uart_dll),
        .uart_dlm_wr(uart_dlm_wr), .uart_dlm(uart_dlm),
        .rtc_cs(rtc_cs), .rtc_wr_n(rtc_wr_n), .rtc_a(rtc_a), .rtc_di(rtc_di),
        .busy(busy), .debug_addr(debug_addr), .debug_data(debug_data),
        .queue_full(queue_full), .queue_empty(queue_empty),
        .queue_wr(queue_wr), .queue_di(queue_di), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       uwr;
        logic [1:0] mode;
        logic       dllwr;
        logic       dlmwr;
        logic       cs;
        logic       wr_n;
        logic       bsy;
        logic [7:0] a;
        logic [7:0] d;
        logic       exp_wr;
        logic [23:0] exp_di;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_strobes();
        uart_tx_wr = 0; uart_dll_wr = 0; uart_dlm_wr = 0;
        rtc_cs = 0; rtc_wr_n = 1; busy = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int nwr;
        reset_n = 0; clear_strobes();
        uart_tx_data = 0; uart_tx_mode = 0; uart_dll = 0; uart_dlm = 0;
        rtc_a = 0; rtc_di = 0; debug_addr = 0; debug_data = 0;
        queue_full = 0; queue_empty = 0;

        vecs[0]  = '{1, 2'd0, 0, 0, 0, 1, 0, 8'h00, 8'h55, 1, 24'hFC0055};
        vecs[1]  = '{1, 2'd1, 0, 0, 0, 1, 0, 8'h00, 8'h66, 1, 24'hFC0366};
        vecs[2]  = '{1, 2'd2, 0, 0, 0, 1, 0, 8'h00, 8'h77, 0, 24'h0};
        vecs[3]  = '{1, 2'd3, 0, 0, 0, 1, 0, 8'h00, 8'h88, 0, 24'h0};
        vecs[4]  = '{0, 2'd0, 1, 0, 0, 1, 0, 8'h00, 8'h0D, 1, 24'hFC010D};
        vecs[5]  = '{0, 2'd0, 0, 1, 0, 1, 0, 8'h00, 8'h7A, 1, 24'hFC027A};
        vecs[6]  = '{0, 2'd0, 0, 0, 1, 0, 0, 8'h0C, 8'h11, 0, 24'h0};
        vecs[7]  = '{0, 2'd0, 0, 0, 1, 0, 0, 8'hF3, 8'h22, 0, 24'h0};
        vecs[8]  = '{0, 2'd0, 0, 0, 1, 0, 1, 8'h05, 8'h33, 0, 24'h0};
        vecs[9]  = '{0, 2'd0, 0, 0, 1, 0, 0, 8'h20, 8'h99, 1, 24'hFA2099};
        vecs[10] = '{0, 2'd0, 0, 0, 1, 1, 0, 8'h21, 8'h44, 0, 24'h0};
        vecs[11] = '{0, 2'd0, 0, 0, 1, 0, 0, 8'hEF, 8'h01, 1, 24'hFAEF01};
        vecs[12] = '{0, 2'd0, 0, 0, 1, 0, 0, 8'h00, 8'h02, 1, 24'hFA0002};

        // Reset state
        idle(2);
        chk("reset queue_wr", queue_wr, 0);
        chk("reset queue_di", queue_di, 0);
        chk("reset drop_cnt", drop_cnt, 0);
        reset_n = 1;
        idle(2);

        // Three simultaneous sources, rr_ptr starting at 0
        uart_tx_wr = 1; uart_tx_mode = 0; uart_tx_data = 8'h41;
        uart_dll_wr = 1; uart_dll = 8'h0D;
        rtc_cs = 1; rtc_wr_n = 0; rtc_a = 8'h05; rtc_di = 8'h12;
        @(negedge clk); clear_strobes();
        @(negedge clk);
        chk("simul wr0", queue_wr, 1); chk("simul di0", queue_di, 24'hFC0041);
        @(negedge clk);
        chk("simul wr1", queue_wr, 1); chk("simul di1", queue_di, 24'hFC010D);
        @(negedge clk);
        chk("simul wr2", queue_wr, 1); chk("simul di2", queue_di, 24'hFA0512);
        @(negedge clk);
        chk("simul idle", queue_wr, 0);
        chk("simul drop", drop_cnt, 0);

        // Single-event vector table
        for (int i = 0; i < 13; i++) begin
            uart_tx_wr = vecs[i].uwr; uart_tx_mode = vecs[i].mode; uart_tx_data = vecs[i].d;
            uart_dll_wr = vecs[i].dllwr; uart_dll = vecs[i].d;
            uart_dlm_wr = vecs[i].dlmwr; uart_dlm = vecs[i].d;
            rtc_cs = vecs[i].cs; rtc_wr_n = vecs[i].wr_n; busy = vecs[i].bsy;
            rtc_a = vecs[i].a; rtc_di = vecs[i].d;
            @(negedge clk); clear_strobes();
            @(negedge clk);
            chk($sformatf("vec%0d wr", i), queue_wr, vecs[i].exp_wr);
            if (vecs[i].exp_wr)
                chk($sformatf("vec%0d di", i), queue_di, vecs[i].exp_di);
            idle(2);
        end
        chk("table drop", drop_cnt, 0);

        // Drop while full: old word kept
        queue_full = 1;
        uart_tx_wr = 1; uart_tx_mode = 0; uart_tx_data = 8'h01;
        @(negedge clk); uart_tx_data = 8'h02;
        @(negedge clk); uart_tx_wr = 0;
        chk("full drop_cnt", drop_cnt, 1);
        @(negedge clk);
        chk("full no wr", queue_wr, 0);
        queue_full = 0;
        @(negedge clk);
        chk("release wr", queue_wr, 1); chk("release di", queue_di, 24'hFC0001);
        @(negedge clk);
        chk("release once", queue_wr, 0);

        // Grant and new event on the same slot: reload, no drop
        uart_tx_wr = 1; uart_tx_data = 8'hA1;
        @(negedge clk); uart_tx_data = 8'hA2;
        @(negedge clk); uart_tx_wr = 0;
        chk("reload wr0", queue_wr, 1); chk("reload di0", queue_di, 24'hFC00A1);
        @(negedge clk);
        chk("reload wr1", queue_wr, 1); chk("reload di1", queue_di, 24'hFC00A2);
        chk("reload drop", drop_cnt, 1);
        idle(1);

        // Debug coalescing while full
        queue_full = 1;
        debug_addr = 16'h1234;
        @(negedge clk); debug_addr = 16'h5678;
        @(negedge clk);
        @(negedge clk);
        chk("dbg drop", drop_cnt, 1);
        queue_full = 0;
        @(negedge clk);
`ifdef MCU_TX_SCHED_DEBUG_EN
        chk("dbg wr", queue_wr, 1); chk("dbg di", queue_di, 24'h305678);
`else
        chk("dbg ignored", queue_wr, 0);
`endif
        @(negedge clk);
        chk("dbg once", queue_wr, 0);
        debug_addr = 16'h0000;
        idle(4);

        // Filler on alternating cycles
        queue_empty = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("fill wr%0d", i), queue_wr, (i % 2 == 0) ? 1 : 0);
            if (i % 2 == 0) chk($sformatf("fill di%0d", i), queue_di, 24'hFF0000);
        end
        queue_empty = 0;
        idle(2);

        // Drop counter saturation
        queue_full = 1;
        uart_tx_wr = 1;
        idle(300);
        uart_tx_wr = 0;
        @(negedge clk);
        chk("drop sat", drop_cnt, 8'hFF);
        queue_full = 0;
        idle(3);

        // Reset mid-operation
        queue_full = 1;
        uart_tx_wr = 1; uart_tx_data = 8'h5A;
        uart_dll_wr = 1; uart_dll = 8'h3C;
        rtc_cs = 1; rtc_wr_n = 0; rtc_a = 8'h07; rtc_di = 8'h08;
        @(negedge clk); clear_strobes();
        queue_full = 0;
        @(posedge clk); #2;
        chk("pre-reset wr", queue_wr, 1);
        reset_n = 0;
        #1;
        chk("async reset wr", queue_wr, 0);
        chk("async reset drop", drop_cnt, 0);
        chk("async reset di", queue_di, 0);
        @(negedge clk); reset_n = 1;
        nwr = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (queue_wr) nwr++;
        end
        chk("no stale writes", nwr, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
